sig_dump_emitter: RTL and testbench
===================================

# sig_dump_emitter

Synthesizable end-of-test signature emitter inside the tiny SoC. On request it walks the integer and FP register files and issues the memory-mapped write sequence the testbench decodes: register dumps, then a stop signature; on a trap it emits a single trap signature write. It sits between the core's debug register-read port and the SoC memory port, arbitrated ahead of the core's own store path.

## Interface
- `NR_INT_REGS`, default 31: integer registers dumped, x1..x`NR_INT_REGS`; x0 is never dumped.
- `FP_EN`, default 1: when 1, dump f0..f31 after the integer registers.
- `ADDR_STOP`, default 64'h0: stop-signature address.
- `ADDR_TRAP`, default 64'h8: trap-signature address.
- `ADDR_INT_DUMP`, default 64'h10: integer dump address; every integer register is written here.
- `ADDR_FP_DUMP`, default 64'h18: FP dump address.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `dump_req_i` in 1: start the dump sequence; level-sampled in IDLE only.
- `trap_req_i` in 1: emit the trap signature; level-sampled in IDLE only.
- `trap_cause_i` in 64: data for the trap write, captured when the trap request is accepted.
- `rf_raddr_o` out 5: register-file read index.
- `rf_fp_o` out 1: 1 selects the FP register file.
- `rf_rdata_i` in 64: read data, valid exactly one cycle after the address.
- `mem_req_o` out 1: write request.
- `mem_gnt_i` in 1: grant; the transfer completes on the cycle where `mem_req_o` and `mem_gnt_i` are both 1.
- `mem_addr_o` out 64: write address.
- `mem_wdata_o` out 64: write data.
- `mem_strb_o` out 8: byte strobes, always 8'hFF while `mem_req_o` is 1.
- `mem_we_o` out 1: equals `mem_req_o`.
- `busy_o` out 1: 1 in every state except IDLE.
- `done_o` out 1: one-cycle pulse after the final write is granted.

## Operation
- States: IDLE, TRAP, RD, WR, STOP, DONE.
- IDLE:
  - `trap_req_i` has priority; if it is 1, capture `trap_cause_i` and go to TRAP.
  - Otherwise, if `dump_req_i` is 1, set index to 1, set `fp_phase` to 0 and go to RD.
  - If both are 1 in the same cycle, only the trap is taken.
- TRAP: drive req with addr `ADDR_TRAP` and the captured cause; on grant go to DONE. No dump follows.
- RD:
  - Drive `rf_raddr_o` with the index and `rf_fp_o` with `fp_phase`.
  - Next cycle go to WR, latching `rf_rdata_i` into the write-data register.
- WR: drive req with addr `ADDR_INT_DUMP` or `ADDR_FP_DUMP` according to `fp_phase`, and the latched data. On grant:
  - Integer phase, index < `NR_INT_REGS`: increment the index and go to RD.
  - Integer phase, last index, `FP_EN`=1: set `fp_phase` to 1, set the index to 0 and go to RD.
  - FP phase, index < 31: increment the index and go to RD.
  - Otherwise: go to STOP.
- STOP: drive req with addr `ADDR_STOP` and wdata 0; on grant go to DONE.
- DONE: pulse `done_o` and go to IDLE.
- `dump_req_i` and `trap_req_i` are ignored while `busy_o` is 1; they are not queued.
- Request stability: while req is 1 without a grant, addr, wdata and strb hold constant and req must not drop.
- The index is a 5-bit counter and never wraps; the terminal compare uses the fixed bounds above.

## Timing
- Reset values: `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `mem_strb_o`=0, `rf_raddr_o`=0, `rf_fp_o`=0, `busy_o`=0, `done_o`=0; state is IDLE.
- All outputs are registered or decoded from state registers only. No combinational path from `mem_gnt_i` to any output.
- Dump accepted at edge N:
  - RD during cycle N+1.
  - First req during N+2.
- With `mem_gnt_i` tied to 1:
  - Each register costs 2 cycles.
  - The full dump with defaults is 31*2 + 32*2 + 1 = 127 cycles from the first RD to the stop grant.
  - `done_o` is high in the cycle after the stop grant.
- Trap accepted at edge N: req during N+1; with immediate grant, `done_o` during N+2.
- Each grant-cycle stall adds exactly one cycle and does not change the write order.
- Asserting `rst_ni` low mid-sequence forces reset values immediately and asynchronously, dropping any pending req. No partial `done_o` is produced.

## Test plan
- Defaults, x_k preloaded with 64'h1000+k, f_k with 64'h2000+k, grant tied to 1, dump pulse:
  - 31 writes to 0x10 carrying 64'h1001..64'h101F in order.
  - Then 32 writes to 0x18 carrying 64'h2000..64'h201F.
  - Then one write to 0x0 with data 0.
  - `done_o` pulses exactly once.
- Same dump with grant random (50%):
  - Identical write sequence.
  - addr and wdata stable during every stall.
  - Req never drops without a grant.
- `trap_req_i` with cause 64'h2, grant tied to 1: one write to 0x8 with data 64'h2; `done_o` two cycles after acceptance; no dump writes.
- `trap_req_i` and `dump_req_i` together: only the trap write appears. Both requests asserted again while busy are ignored.
- `FP_EN`=0: 31 integer writes, then stop, with no 0x18 writes; 63 cycles to the stop grant with grant tied to 1.
- `rst_ni` asserted after the 10th integer write: all outputs return to reset values in the same cycle. A new dump after release restarts at x1.

Source files
------------

// File: rtl/sig_dump_emitter.sv
// sig_dump_emitter: end-of-test signature emitter.
// On a dump request it reads x1..xN (and optionally f0..f31) through the
// debug register-read port and writes each value to a fixed dump address.
// It then writes a stop signature. On a trap request it writes a single
// trap signature carrying the captured cause.
// All outputs come straight from registers. mem_gnt_i only steers the
// next state, so it has no combinational path to any output.

module sig_dump_emitter #(
  parameter int unsigned NR_INT_REGS   = 31,
  parameter bit          FP_EN         = 1'b1,
  parameter logic [63:0] ADDR_STOP     = 64'h0,
  parameter logic [63:0] ADDR_TRAP     = 64'h8,
  parameter logic [63:0] ADDR_INT_DUMP = 64'h10,
  parameter logic [63:0] ADDR_FP_DUMP  = 64'h18
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dump_req_i,
  input  logic        trap_req_i,
  input  logic [63:0] trap_cause_i,
  output logic [4:0]  rf_raddr_o,
  output logic        rf_fp_o,
  input  logic [63:0] rf_rdata_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_strb_o,
  output logic        mem_we_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TRAP = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_STOP = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Terminal indices of the two phases; the index counter never wraps.
  localparam logic [4:0] LAST_INT_IDX = 5'(NR_INT_REGS);
  localparam logic [4:0] LAST_FP_IDX  = 5'd31;
  localparam logic [7:0] STRB_ALL     = 8'hFF;

  state_e      state_q;
  logic [4:0]  idx_q;
  logic        fp_phase_q;
  logic [4:0]  rf_raddr_q;
  logic        rf_fp_q;
  logic        mem_req_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_wdata_q;
  logic [7:0]  mem_strb_q;
  logic        busy_q;
  logic        done_q;

  // Sequencer: state, index/phase bookkeeping and every registered output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      idx_q       <= 5'd0;
      fp_phase_q  <= 1'b0;
      rf_raddr_q  <= 5'd0;
      rf_fp_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 64'h0;
      mem_wdata_q <= 64'h0;
      mem_strb_q  <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // done_o is a single-cycle pulse; only the entry into DONE raises it.
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (trap_req_i) begin
            // The trap wins over a simultaneous dump request. The cause is
            // captured straight into the write-data register.
            state_q     <= ST_TRAP;
            busy_q      <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= ADDR_TRAP;
            mem_wdata_q <= trap_cause_i;
            mem_strb_q  <= STRB_ALL;
          end else if (dump_req_i) begin
            state_q    <= ST_RD;
            busy_q     <= 1'b1;
            idx_q      <= 5'd1;
            fp_phase_q <= 1'b0;
            rf_raddr_q <= 5'd1;
            rf_fp_q    <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_TRAP: begin
          if (mem_gnt_i) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 64'h0;
            mem_wdata_q <= 64'h0;
            mem_strb_q  <= 8'h00;
          end else begin
            state_q <= ST_TRAP;
          end
        end

        ST_RD: begin
          // Read data is valid by the end of the cycle that presents the index.
          state_q     <= ST_WR;
          mem_req_q   <= 1'b1;
          mem_addr_q  <= fp_phase_q ? ADDR_FP_DUMP : ADDR_INT_DUMP;
          mem_wdata_q <= rf_rdata_i;
          mem_strb_q  <= STRB_ALL;
        end

        ST_WR: begin
          if (mem_gnt_i) begin
            if (!fp_phase_q && (idx_q < LAST_INT_IDX)) begin
              state_q     <= ST_RD;
              idx_q       <= idx_q + 5'd1;
              rf_raddr_q  <= idx_q + 5'd1;
              mem_req_q   <= 1'b0;
              mem_addr_q  <= 64'h0;
              mem_wdata_q <= 64'h0;
              mem_strb_q  <= 8'h00;
            end else if (!fp_phase_q && FP_EN) begin
              // Integer phase finished; the FP file starts at f0.
              state_q     <= ST_RD;
              fp_phase_q  <= 1'b1;
              idx_q       <= 5'd0;
              rf_raddr_q  <= 5'd0;
              rf_fp_q     <= 1'b1;
              mem_req_q   <= 1'b0;
              mem_addr_q  <= 64'h0;
              mem_wdata_q <= 64'h0;
              mem_strb_q  <= 8'h00;
            end else if (fp_phase_q && (idx_q < LAST_FP_IDX)) begin
              state_q     <= ST_RD;
              idx_q       <= idx_q + 5'd1;
              rf_raddr_q  <= idx_q + 5'd1;
              mem_req_q   <= 1'b0;
              mem_addr_q  <= 64'h0;
              mem_wdata_q <= 64'h0;
              mem_strb_q  <= 8'h00;
            end else begin
              // The last dump write completed; the stop request goes out next.
              state_q     <= ST_STOP;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= ADDR_STOP;
              mem_wdata_q <= 64'h0;
              mem_strb_q  <= STRB_ALL;
            end
          end else begin
            state_q <= ST_WR;
          end
        end

        ST_STOP: begin
          if (mem_gnt_i) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 64'h0;
            mem_wdata_q <= 64'h0;
            mem_strb_q  <= 8'h00;
          end else begin
            state_q <= ST_STOP;
          end
        end

        ST_DONE: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          idx_q      <= 5'd0;
          fp_phase_q <= 1'b0;
          rf_raddr_q <= 5'd0;
          rf_fp_q    <= 1'b0;
        end

        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          mem_req_q   <= 1'b0;
          mem_addr_q  <= 64'h0;
          mem_wdata_q <= 64'h0;
          mem_strb_q  <= 8'h00;
        end
      endcase
    end
  end

  assign rf_raddr_o  = rf_raddr_q;
  assign rf_fp_o     = rf_fp_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_strb_o  = mem_strb_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_sig_dump_emitter.sv
// Testbench for sig_dump_emitter: scoreboard of expected memory writes,
// default instance (FP dump enabled) plus an FP_EN=0 instance.
`timescale 1ns/1ps
module tb_sig_dump_emitter;

  logic        clk = 1'b0;
  logic        rst_n;
  // default instance
  logic        dump_req, trap_req;
  logic [63:0] trap_cause;
  logic [4:0]  rf_raddr;
  logic        rf_fp;
  logic [63:0] rf_rdata;
  logic        mem_req, gnt, we, busy, done;
  logic [63:0] addr, wdata;
  logic [7:0]  strb;
  // FP_EN=0 instance
  logic        dump_req1, trap_req1;
  logic [63:0] trap_cause1;
  logic [4:0]  rf_raddr1;
  logic        rf_fp1;
  logic [63:0] rf_rdata1;
  logic        mem_req1, gnt1, we1, busy1, done1;
  logic [63:0] addr1, wdata1;
  logic [7:0]  strb1;

  int checks = 0;
  int failures = 0;
  bit rand_gnt = 1'b0;
  int cyc = 0;

  logic [127:0] exp_q[$];
  logic [127:0] exp1_q[$];
  logic [127:0] e0, e1;

  // monitor state, default instance
  bit          stall0 = 1'b0, busy_prev0 = 1'b0;
  logic [63:0] st_addr0, st_data0;
  int rise0 = 0, stop_cyc0 = 0, done_cyc0 = 0, done_cnt0 = 0;
  int int_wr0 = 0, fp_wr0 = 0;
  logic rise_req0 = 1'b0;
  // monitor state, FP_EN=0 instance
  bit busy_prev1 = 1'b0;
  int rise1 = 0, stop_cyc1 = 0, done_cnt1 = 0, int_wr1 = 0, fp_wr1 = 0;

  sig_dump_emitter u_dut (
    .clk_i(clk), .rst_ni(rst_n), .dump_req_i(dump_req), .trap_req_i(trap_req),
    .trap_cause_i(trap_cause), .rf_raddr_o(rf_raddr), .rf_fp_o(rf_fp),
    .rf_rdata_i(rf_rdata), .mem_req_o(mem_req), .mem_gnt_i(gnt),
    .mem_addr_o(addr), .mem_wdata_o(wdata), .mem_strb_o(strb), .mem_we_o(we),
    .busy_o(busy), .done_o(done)
  );

  sig_dump_emitter #(.FP_EN(1'b0)) u_dut_nofp (
    .clk_i(clk), .rst_ni(rst_n), .dump_req_i(dump_req1), .trap_req_i(trap_req1),
    .trap_cause_i(trap_cause1), .rf_raddr_o(rf_raddr1), .rf_fp_o(rf_fp1),
    .rf_rdata_i(rf_rdata1), .mem_req_o(mem_req1), .mem_gnt_i(gnt1),
    .mem_addr_o(addr1), .mem_wdata_o(wdata1), .mem_strb_o(strb1), .mem_we_o(we1),
    .busy_o(busy1), .done_o(done1)
  );

  always #5 clk = ~clk;

  // Register files: x_k = 0x1000+k, f_k = 0x2000+k, combinational read.
  assign rf_rdata  = rf_fp  ? (64'h2000 + {59'd0, rf_raddr})  : (64'h1000 + {59'd0, rf_raddr});
  assign rf_rdata1 = rf_fp1 ? (64'h2000 + {59'd0, rf_raddr1}) : (64'h1000 + {59'd0, rf_raddr1});

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit which, input logic [63:0] a, input logic [63:0] d);
    if (which) exp1_q.push_back({a, d});
    else       exp_q.push_back({a, d});
  endtask

  task automatic push_dump(input bit which, input bit fp_en);
    for (int k = 1; k <= 31; k++) push_exp(which, 64'h10, 64'h1000 + 64'(k));
    if (fp_en) begin
      for (int k = 0; k <= 31; k++) push_exp(which, 64'h18, 64'h2000 + 64'(k));
    end
    push_exp(which, 64'h0, 64'h0);
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_req"},   64'(mem_req),  64'd0);
    check_val({tag, "_we"},    64'(we),       64'd0);
    check_val({tag, "_addr"},  addr,          64'd0);
    check_val({tag, "_wdata"}, wdata,         64'd0);
    check_val({tag, "_strb"},  64'(strb),     64'd0);
    check_val({tag, "_raddr"}, 64'(rf_raddr), 64'd0);
    check_val({tag, "_rffp"},  64'(rf_fp),    64'd0);
    check_val({tag, "_busy"},  64'(busy),     64'd0);
    check_val({tag, "_done"},  64'(done),     64'd0);
  endtask

  task automatic pulse_dump(input bit which);
    @(posedge clk); #1;
    if (which) dump_req1 = 1'b1; else dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req1 = 1'b0;
    dump_req  = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int start_cnt, input int budget);
    int n = 0;
    while (((which ? done_cnt1 : done_cnt0) == start_cnt) && (n < budget)) begin
      @(negedge clk); #1;
      n++;
    end
    check_val(which ? "done1_seen" : "done0_seen", 64'((which ? done_cnt1 : done_cnt0) - start_cnt), 64'd1);
  endtask

  // Grant driver, changed just after each rising edge.
  initial begin
    gnt  = 1'b1;
    gnt1 = 1'b1;
    forever begin
      @(posedge clk); #1;
      gnt = rand_gnt ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  always @(posedge clk) cyc++;

  // Monitors: scoreboard compare on every granted write, stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall0 = 1'b0;
      busy_prev0 = 1'b0;
      busy_prev1 = 1'b0;
    end else begin
      if (busy && !busy_prev0) begin rise0 = cyc; rise_req0 = mem_req; end
      busy_prev0 = busy;
      if (done) begin done_cnt0++; done_cyc0 = cyc; end
      if (stall0) begin
        check_val("req_held", 64'(mem_req), 64'd1);
        if (mem_req) begin
          check_val("addr_stable", addr, st_addr0);
          check_val("wdata_stable", wdata, st_data0);
        end
      end
      if (mem_req && gnt) begin
        e0 = (exp_q.size() != 0) ? exp_q.pop_front() : {64'hDEAD_0000_0000_DEAD, 64'hDEAD};
        check_val("wr_addr", addr, e0[127:64]);
        check_val("wr_data", wdata, e0[63:0]);
        check_val("wr_strb", 64'(strb), 64'hFF);
        check_val("wr_we", 64'(we), 64'd1);
        if (addr == 64'h10) int_wr0++;
        if (addr == 64'h18) fp_wr0++;
        if (addr == 64'h0)  stop_cyc0 = cyc;
        stall0 = 1'b0;
      end else if (mem_req) begin
        stall0 = 1'b1;
        st_addr0 = addr;
        st_data0 = wdata;
      end else begin
        stall0 = 1'b0;
      end

      if (busy1 && !busy_prev1) rise1 = cyc;
      busy_prev1 = busy1;
      if (done1) done_cnt1++;
      if (mem_req1 && gnt1) begin
        e1 = (exp1_q.size() != 0) ? exp1_q.pop_front() : {64'hDEAD_0000_0000_DEAD, 64'hDEAD};
        check_val("wr1_addr", addr1, e1[127:64]);
        check_val("wr1_data", wdata1, e1[63:0]);
        if (addr1 == 64'h10) int_wr1++;
        if (addr1 == 64'h18) fp_wr1++;
        if (addr1 == 64'h0)  stop_cyc1 = cyc;
      end
    end
  end

  initial begin
    int base_done, base_int, base_fp, n;
    rst_n = 1'b0;
    dump_req = 1'b0; trap_req = 1'b0; trap_cause = 64'h0;
    dump_req1 = 1'b0; trap_req1 = 1'b0; trap_cause1 = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst");
    check_val("rst_nofp_req", 64'(mem_req1), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("idle");

    // Full dump, grant tied high.
    push_dump(1'b0, 1'b1);
    base_done = done_cnt0; base_int = int_wr0; base_fp = fp_wr0;
    pulse_dump(1'b0);
    wait_done(1'b0, base_done, 400);
    repeat (5) @(negedge clk);
    #1;
    check_val("A_done_once", 64'(done_cnt0 - base_done), 64'd1);
    check_val("A_sb_empty", 64'(exp_q.size()), 64'd0);
    check_val("A_int_writes", 64'(int_wr0 - base_int), 64'd31);
    check_val("A_fp_writes", 64'(fp_wr0 - base_fp), 64'd32);
    check_val("A_cycles", 64'(stop_cyc0 - rise0 + 1), 64'd127);
    check_val("A_done_after_stop", 64'(done_cyc0 - stop_cyc0), 64'd1);
    check_val("A_idle_busy", 64'(busy), 64'd0);

    // Same dump with a 50% random grant.
    rand_gnt = 1'b1;
    push_dump(1'b0, 1'b1);
    base_done = done_cnt0; base_int = int_wr0; base_fp = fp_wr0;
    pulse_dump(1'b0);
    wait_done(1'b0, base_done, 2000);
    repeat (5) @(negedge clk);
    #1;
    check_val("B_done_once", 64'(done_cnt0 - base_done), 64'd1);
    check_val("B_sb_empty", 64'(exp_q.size()), 64'd0);
    check_val("B_int_writes", 64'(int_wr0 - base_int), 64'd31);
    check_val("B_fp_writes", 64'(fp_wr0 - base_fp), 64'd32);
    rand_gnt = 1'b0;
    repeat (2) @(posedge clk);

    // Trap with cause 2, grant tied high.
    push_exp(1'b0, 64'h8, 64'h2);
    base_done = done_cnt0; base_int = int_wr0;
    @(posedge clk); #1;
    trap_req = 1'b1; trap_cause = 64'h2;
    @(posedge clk); #1;
    trap_req = 1'b0; trap_cause = 64'h0;
    wait_done(1'b0, base_done, 50);
    repeat (5) @(negedge clk);
    #1;
    check_val("C_req_after_accept", 64'(rise_req0), 64'd1);
    check_val("C_done_latency", 64'(done_cyc0 - rise0), 64'd1);
    check_val("C_sb_empty", 64'(exp_q.size()), 64'd0);
    check_val("C_no_dump", 64'(int_wr0 - base_int), 64'd0);
    check_val("C_done_once", 64'(done_cnt0 - base_done), 64'd1);

    // Trap and dump together, both held while busy; random grant.
    rand_gnt = 1'b1;
    push_exp(1'b0, 64'h8, 64'h55);
    base_done = done_cnt0; base_int = int_wr0;
    @(posedge clk); #1;
    trap_req = 1'b1; dump_req = 1'b1; trap_cause = 64'h55;
    @(posedge clk); #1;
    trap_cause = 64'hBAD;
    n = 0;
    while (busy && (n < 200)) begin
      @(posedge clk); #1;
      n++;
    end
    trap_req = 1'b0; dump_req = 1'b0; trap_cause = 64'h0;
    check_val("D_busy_ended", 64'(busy), 64'd0);
    repeat (6) @(negedge clk);
    #1;
    check_val("D_done_once", 64'(done_cnt0 - base_done), 64'd1);
    check_val("D_sb_empty", 64'(exp_q.size()), 64'd0);
    check_val("D_no_dump", 64'(int_wr0 - base_int), 64'd0);
    check_val("D_idle", 64'(busy), 64'd0);
    rand_gnt = 1'b0;
    repeat (2) @(posedge clk);

    // FP_EN=0 instance.
    push_dump(1'b1, 1'b0);
    base_done = done_cnt1;
    pulse_dump(1'b1);
    wait_done(1'b1, base_done, 200);
    repeat (5) @(negedge clk);
    #1;
    check_val("E_sb_empty", 64'(exp1_q.size()), 64'd0);
    check_val("E_int_writes", 64'(int_wr1), 64'd31);
    check_val("E_fp_writes", 64'(fp_wr1), 64'd0);
    check_val("E_cycles", 64'(stop_cyc1 - rise1 + 1), 64'd63);
    check_val("E_done_once", 64'(done_cnt1 - base_done), 64'd1);

    // Reset after the 10th integer write, then a fresh dump.
    push_dump(1'b0, 1'b1);
    base_done = done_cnt0; base_int = int_wr0;
    pulse_dump(1'b0);
    n = 0;
    while (((int_wr0 - base_int) < 10) && (n < 100)) begin
      @(negedge clk); #1;
      n++;
    end
    check_val("F_int_before_rst", 64'(int_wr0 - base_int), 64'd10);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outs("F_async");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check_val("F_no_partial_done", 64'(done_cnt0 - base_done), 64'd0);
    rst_n = 1'b1;
    push_dump(1'b0, 1'b1);
    base_done = done_cnt0; base_int = int_wr0;
    pulse_dump(1'b0);
    wait_done(1'b0, base_done, 400);
    repeat (5) @(negedge clk);
    #1;
    check_val("F_restart_sb_empty", 64'(exp_q.size()), 64'd0);
    check_val("F_restart_int", 64'(int_wr0 - base_int), 64'd31);
    check_val("F_restart_done_once", 64'(done_cnt0 - base_done), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
